// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

   // Size code used for every instruction fetch (full word)
   localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/arb_latency_ctr.sv
// Loadable down-counter timing the memory read latency; flags when it reaches zero.
module arb_latency_ctr #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned CW          = $clog2(MEM_LATENCY + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [CW-1:0] LoadVal = CW'(MEM_LATENCY - 1);

   logic [CW-1:0] count;

   // Load on issue, then count down to zero and stop there
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= LoadVal;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory, one access
// in flight, data first with a bounded starvation guard for fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_valid,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic [2:0]            dm_size,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_valid,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_size,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stallF,
   output logic                  stallM,
   output logic                  busy
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

   arb_state_t    state;
   owner_t        owner;
   logic [SW-1:0] starveCnt;
   logic          latZero;
   logic          grantData;

   arb_latency_ctr #(
      .MEM_LATENCY (MEM_LATENCY)
   ) uLatCtr (
      .clk  (clk),
      .rst  (rst),
      .load (state == ISSUE),
      .dec  (state == WAIT),
      .zero (latZero)
   );

   // Data wins unless fetch has already been passed over STARVE_LIMIT times
   assign grantData = dm_req && (!if_req || (starveCnt < StarveMax));

   // Access sequencer with registered memory strobes and completion pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         starveCnt <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_size  <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
      end else begin
         mem_req  <= 1'b0;
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grantData) begin
                  owner     <= OWN_DM;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_size  <= dm_size;
                  starveCnt <= if_req ? starveCnt + SW'(1) : '0;
                  mem_req   <= 1'b1;
                  state     <= ISSUE;
               end else if (if_req) begin
                  owner     <= OWN_IF;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_size  <= SIZE_WORD;
                  starveCnt <= '0;
                  mem_req   <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (latZero) begin
                  if (owner == OWN_IF) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_valid <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stallF = if_req & ~if_valid;
   assign stallM = dm_req & ~dm_valid;
   assign busy   = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-ported memory between the pipelined core's instruction-fetch port and its MEM-stage data port.
- Serialises requests onto the memory: one outstanding access at a time, data port has priority, with a starvation guard for fetch.
- Produces fetch and memory-stage stall signals for the hazard logic, so the pipeline freezes while an access is pending.

Parameters:
ADDR_WIDTH, 32, byte address width of all ports
DATA_WIDTH, 32, data width of all ports
MEM_LATENCY, 2, cycles from the mem_req cycle to the cycle mem_rdata is valid (legal range 1-15)
STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced (must be 1 or more)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched instruction; held until next fetch completion
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with its qualifiers stable until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_size  in  3  funct3 size/sign code, passed through unchanged
dm_rdata  out  DATA_WIDTH  load data; held until next data completion
dm_valid  out  1  one-cycle completion pulse for data (loads and stores)
mem_req  out  1  one-cycle access strobe to memory
mem_we  out  1  write enable to memory
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_size  out  3  size code to memory (3'b010 for fetch)
mem_rdata  in  DATA_WIDTH  memory read data
stallF  out  1  if_req & ~if_valid (combinational)
stallM  out  1  dm_req & ~dm_valid (combinational)
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst low): state IDLE; all registered outputs 0; owner register cleared; starve counter 0; latency counter 0.
- Reset mid-access drops mem_req immediately. The in-flight result is discarded and produces no valid pulse.

FSM, one access in flight:
- IDLE: if any request is pending, grant it, latch owner and all qualifiers into the mem_* registers, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): mem_req=1. Load the latency counter with MEM_LATENCY-1. Go to WAIT.
- WAIT: mem_req=0. Decrement the counter each cycle. At counter==0, capture mem_rdata into the owner's rdata register (stores leave dm_rdata unchanged) and go to DONE.
- DONE (1 cycle): pulse the owner's valid. Go to IDLE. Requests are not sampled in DONE, so a requester still holding req during its valid cycle is not re-granted.

Timing and holds:
- Latency: request seen in IDLE at cycle t gives valid at t+MEM_LATENCY+2. With the default, valid is at t+4 and the next grant is possible at t+5.
- mem_we, mem_addr, mem_wdata and mem_size hold their values from ISSUE until the next grant.
- if_rdata and dm_rdata hold their values until their own next completion.

Arbitration, evaluated in IDLE only:
- Only dm_req pending: grant data. Only if_req pending: grant fetch.
- Both pending and starve counter < STARVE_LIMIT: grant data, increment the counter.
- Both pending and counter == STARVE_LIMIT: grant fetch.
- Any fetch grant resets the counter to 0. A data grant with if_req low also resets it to 0.
- The counter saturates and never wraps.

Other rules:
- Requests that drop before being granted are simply not served.
- Requests that drop after being granted still complete normally; the valid pulse is produced and ignored by the requester.
- Fetch accesses always use mem_we=0 and mem_size=3'b010.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}
  - owner_t enum {OWN_IF, OWN_DM}
  - localparam SIZE_WORD = 3'b010
- One natural sub-module, arb_latency_ctr: a loadable down-counter with a zero flag, width $clog2(MEM_LATENCY+1).

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000010, mem_rdata=0x00500093 in the capture cycle -> mem_req pulses once at t+1 with mem_addr=0x10, mem_we=0; if_valid pulses at t+4 with if_rdata=0x00500093; stallF=1 from t to t+3.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_size=3'b010 -> at t+1 mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; dm_valid at t+4; dm_rdata unchanged.
- Conflict: if_req and dm_req rise together -> data granted first (dm_valid at t+4); fetch granted at t+5; if_valid at t+9.
- Starvation: if_req held high, dm_req re-asserted after every dm_valid -> exactly 4 consecutive data grants, then one fetch grant, then data resumes.
- Reset mid-access: rst driven low in WAIT -> mem_req=0 and busy=0 immediately; no valid pulse; after release, a new fetch completes normally with MEM_LATENCY+2 latency.
- MEM_LATENCY=1 build: fetch request -> valid at t+3; back-to-back fetches every 4 cycles.
